mux2to1_output: RTL and testbench
=================================

# mux2to1_output

Registered result-select stage at the output of the adder datapath. It chooses between the adder result (`sum`/`co`) and a 6-bit compare/status word (`com_res`) and presents the selection on a single registered result bus. This is the last stage before the block boundary, so the scan chain observes a flopped result.

## Interface
- `N`, default 16: width of `sum` and `sel_res`.
- `CW`, default 6: width of `com_res`. `N >= CW` is required. Elaboration fails otherwise.

- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `sum`  in  N: adder sum.
- `co`  in  1: adder carry-out.
- `com_res`  in  CW: compare/status result.
- `sel`  in  1: 0 selects adder path, 1 selects compare path.
- `in_valid`  in  1: qualifies the inputs for this cycle.
- `sel_res`  out  N: registered selected result.
- `sel_co`  out  1: registered selected carry.
- `out_valid`  out  1: `sel_res`/`sel_co` were loaded on the last edge.
- `sel_par`  out  1: even parity of {`sel_co`, `sel_res`}. Present only with `MUX2TO1_OUTPUT_PARITY_EN`.

## Operation
- Next-state select:
  - `sel`=0: result = `sum`, carry = `co`.
  - `sel`=1: result = {(N-CW)'0, `com_res`} (zero-extended), carry = 0.
- Load behaviour:
  - On an edge with `rst`=0 and `in_valid`=1, `sel_res`/`sel_co` load the selected values.
  - On an edge with `rst`=0 and `in_valid`=0, they hold their previous values.
- `out_valid` loads `in_valid` on every non-reset edge.
- `sel` is sampled only on edges where `in_valid`=1. Toggling `sel` while `in_valid`=0 has no effect.
- Unknown (X) on `sel` with `in_valid`=1 is a bench assertion failure. RTL does not filter it.
- There is no arithmetic in this block. It selects and zero-extends only, with no sign extension.

## Timing
- Latency: 1 cycle from inputs sampled at edge k to outputs valid after edge k.
- Reset (`rst`=1 at an edge): `sel_res`=0, `sel_co`=0, `out_valid`=0, `sel_par`=0. Reset overrides `in_valid`.
- Reset asserted mid-stream: the result in flight is discarded. The first valid output after reset appears one edge after the first `in_valid`=1 edge with `rst`=0.
- Back-to-back `in_valid`=1 gives one new output per cycle. There is no backpressure.
- All outputs are driven directly from flops. There is no combinational path from input to output.

## Configuration
- Macro `MUX2TO1_OUTPUT_PARITY_EN`.
- Defined:
  - `sel_par` port exists.
  - A flop loads the XOR-reduction of {carry, result} on the same load condition as `sel_res`.
  - It resets to 0 and holds when `in_valid`=0.
- Undefined: no `sel_par` port and no parity logic. All other behaviour is identical.

## Structure
- Shared package `mux2to1_output_pkg`:
  - `SEL_ADD`=1'b0 and `SEL_CMP`=1'b1 select encodings.
  - Default widths `N_DEF`=16, `CW_DEF`=6.
  - A `zext_cmp` function for the zero-extension.
- One sub-module, `mux2to1_output_sel`: the purely combinational select and zero-extend (plus parity when enabled).
- The top level holds the flops, the valid pipeline and the `N >= CW` elaboration check.

## Test plan
- Reset: `rst`=1 for 2 edges with `sum`=16'hFFFF, `co`=1, `in_valid`=1 -> `sel_res`=16'h0000, `sel_co`=0, `out_valid`=0.
- Adder path: `sum`=16'h0000, `co`=0, `com_res`=6'h3F, `sel`=0, `in_valid`=1 -> next edge `sel_res`=16'h0000, `sel_co`=0, `out_valid`=1.
- Compare path: same inputs, `sel`=1 -> next edge `sel_res`=16'h003F, `sel_co`=0. Then `sum`=16'hFFFF, `co`=1, `sel`=1 -> `sel_res`=16'h003F, `sel_co`=0.
- Hold: load `sum`=16'hA5A5, `co`=1, `sel`=0; then `in_valid`=0 with `sum`=16'h1234 and `sel` toggling for 3 cycles -> `sel_res` stays 16'hA5A5, `sel_co`=1, `out_valid`=0.
- Mid-stream reset: valid stream with `sum`=16'h0001..0004; `rst`=1 on the 3rd edge -> outputs 0 at that edge, and the next valid output follows the first post-reset `in_valid` edge.
- Parity (macro defined): `sel_res`=16'h0001, `sel_co`=0 -> `sel_par`=1; `sel_res`=16'h0003, `sel_co`=1 -> `sel_par`=1; `sel_res`=16'h003F, `sel_co`=0 -> `sel_par`=0.

Source files
------------

// File: rtl/mux2to1_output_pkg.sv
// Shared select encodings, default widths and zero-extension helper for the
// mux2to1_output result-select stage.
package mux2to1_output_pkg;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_CMP = 1'b1;

    localparam int N_DEF  = 16;
    localparam int CW_DEF = 6;

    // Widest result bus the helper can build; the top rejects larger N.
    localparam int MAX_W = 64;

    // Keeps the low cw bits of cmp and clears everything above them.
    function automatic logic [MAX_W-1:0] zext_cmp(input logic [MAX_W-1:0] cmp, input int cw);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < cw) r[i] = cmp[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mux2to1_output_sel.sv
// Combinational next-state select for mux2to1_output: adder path or
// zero-extended compare word, plus parity when MUX2TO1_OUTPUT_PARITY_EN is set.
module mux2to1_output_sel
    import mux2to1_output_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          sel,
    input  logic [N-1:0]  sum,
    input  logic          co,
    input  logic [CW-1:0] com_res,
`ifdef MUX2TO1_OUTPUT_PARITY_EN
    output logic          par_nxt,
`endif
    output logic [N-1:0]  res_nxt,
    output logic          co_nxt
);

    logic [MAX_W-1:0] cmp_wide;
    logic [MAX_W-1:0] cmp_ext;

    assign cmp_wide = MAX_W'(com_res);
    assign cmp_ext  = zext_cmp(cmp_wide, CW);

    always_comb begin
        res_nxt = sum;
        co_nxt  = co;
        if (sel == SEL_CMP) begin
            res_nxt = cmp_ext[N-1:0];
            co_nxt  = 1'b0;
        end
    end

`ifdef MUX2TO1_OUTPUT_PARITY_EN
    assign par_nxt = ^{co_nxt, res_nxt};
`endif

endmodule

// File: rtl/mux2to1_output.sv
// Registered result-select stage at the adder datapath output; every output
// comes straight from a flop. Optional sel_par via MUX2TO1_OUTPUT_PARITY_EN.
module mux2to1_output
    import mux2to1_output_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  sum,
    input  logic          co,
    input  logic [CW-1:0] com_res,
    input  logic          sel,
    input  logic          in_valid,
    output logic [N-1:0]  sel_res,
    output logic          sel_co,
`ifdef MUX2TO1_OUTPUT_PARITY_EN
    output logic          sel_par,
`endif
    output logic          out_valid
);

    if (N < CW) begin : g_bad_width
        $error("mux2to1_output: N (%0d) must be >= CW (%0d)", N, CW);
    end
    if (N > MAX_W) begin : g_too_wide
        $error("mux2to1_output: N (%0d) exceeds MAX_W (%0d)", N, MAX_W);
    end

    logic [N-1:0] res_nxt;
    logic         co_nxt;

    logic [N-1:0] sel_res_d, sel_res_q;
    logic         sel_co_d,  sel_co_q;
    logic         out_valid_d, out_valid_q;

`ifdef MUX2TO1_OUTPUT_PARITY_EN
    logic par_nxt;
    logic sel_par_d, sel_par_q;
`endif

    mux2to1_output_sel #(.N(N), .CW(CW)) u_sel (
        .sel     (sel),
        .sum     (sum),
        .co      (co),
        .com_res (com_res),
`ifdef MUX2TO1_OUTPUT_PARITY_EN
        .par_nxt (par_nxt),
`endif
        .res_nxt (res_nxt),
        .co_nxt  (co_nxt)
    );

    // Result flops hold unless the inputs are qualified; valid follows in_valid.
    always_comb begin
        sel_res_d   = sel_res_q;
        sel_co_d    = sel_co_q;
        out_valid_d = in_valid;
`ifdef MUX2TO1_OUTPUT_PARITY_EN
        sel_par_d   = sel_par_q;
`endif
        if (in_valid) begin
            sel_res_d = res_nxt;
            sel_co_d  = co_nxt;
`ifdef MUX2TO1_OUTPUT_PARITY_EN
            sel_par_d = par_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_res_q   <= '0;
            sel_co_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MUX2TO1_OUTPUT_PARITY_EN
            sel_par_q   <= 1'b0;
`endif
        end else begin
            sel_res_q   <= sel_res_d;
            sel_co_q    <= sel_co_d;
            out_valid_q <= out_valid_d;
`ifdef MUX2TO1_OUTPUT_PARITY_EN
            sel_par_q   <= sel_par_d;
`endif
        end
    end

    assign sel_res   = sel_res_q;
    assign sel_co    = sel_co_q;
    assign out_valid = out_valid_q;
`ifdef MUX2TO1_OUTPUT_PARITY_EN
    assign sel_par   = sel_par_q;
`endif

endmodule

// File: tb/tb_mux2to1_output.sv
// Directed and random checks of mux2to1_output against a behavioural model.
// Parity is checked too when MUX2TO1_OUTPUT_PARITY_EN is defined.
module tb_mux2to1_output;

    localparam int N  = 16;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  sum = '0;
    logic          co = 1'b0;
    logic [CW-1:0] com_res = '0;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  sel_res;
    logic          sel_co;
    logic          out_valid;
`ifdef MUX2TO1_OUTPUT_PARITY_EN
    logic          sel_par;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model state: what the outputs should show after the last edge.
    logic [N-1:0] m_res = '0;
    logic         m_co = 1'b0;
    logic         m_vld = 1'b0;
    logic         m_par = 1'b0;

    mux2to1_output #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sum       (sum),
        .co        (co),
        .com_res   (com_res),
        .sel       (sel),
        .in_valid  (in_valid),
        .sel_res   (sel_res),
        .sel_co    (sel_co),
`ifdef MUX2TO1_OUTPUT_PARITY_EN
        .sel_par   (sel_par),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        n_cmp++;
        assert (sel_res === m_res) else begin
            n_err++;
            $error("FAIL %s sel_res got %h expected %h", tag, sel_res, m_res);
        end
        n_cmp++;
        assert (sel_co === m_co) else begin
            n_err++;
            $error("FAIL %s sel_co got %b expected %b", tag, sel_co, m_co);
        end
        n_cmp++;
        assert (out_valid === m_vld) else begin
            n_err++;
            $error("FAIL %s out_valid got %b expected %b", tag, out_valid, m_vld);
        end
`ifdef MUX2TO1_OUTPUT_PARITY_EN
        n_cmp++;
        assert (sel_par === m_par) else begin
            n_err++;
            $error("FAIL %s sel_par got %b expected %b", tag, sel_par, m_par);
        end
`endif
    endtask

    // One clock: drive at negedge, update the model at posedge, check 1 unit later.
    task automatic step(input string tag, input logic r, input logic [N-1:0] s,
                        input logic c, input logic [CW-1:0] cm, input logic sl,
                        input logic v);
        @(negedge clk);
        rst = r; sum = s; co = c; com_res = cm; sel = sl; in_valid = v;
        @(posedge clk);
        if (v && !r) begin
            assert (!$isunknown(sel)) else $error("sel unknown while in_valid");
        end
        if (r) begin
            m_res = '0; m_co = 1'b0; m_vld = 1'b0; m_par = 1'b0;
        end else begin
            m_vld = v;
            if (v) begin
                if (sl) begin
                    m_res = N'(int'(cm));
                    m_co  = 1'b0;
                end else begin
                    m_res = s;
                    m_co  = c;
                end
                m_par = ($countones(m_res) + int'(m_co)) % 2 == 1;
            end
        end
        #1;
        check(tag);
    endtask

    initial begin
        // Reset overrides a qualified input.
        step("rst0", 1, 16'hFFFF, 1, 6'h00, 0, 1);
        step("rst1", 1, 16'hFFFF, 1, 6'h00, 0, 1);

        step("add_zero", 0, 16'h0000, 0, 6'h3F, 0, 1);
        step("cmp_3f",   0, 16'h0000, 0, 6'h3F, 1, 1);
        step("cmp_noco", 0, 16'hFFFF, 1, 6'h3F, 1, 1);

        // Hold with sel toggling while unqualified.
        step("load_a5",  0, 16'hA5A5, 1, 6'h15, 0, 1);
        step("hold0",    0, 16'h1234, 0, 6'h2A, 1, 0);
        step("hold1",    0, 16'h1234, 0, 6'h2A, 0, 0);
        step("hold2",    0, 16'h1234, 0, 6'h2A, 1, 0);

        // Reset in the middle of a valid stream.
        step("strm1",    0, 16'h0001, 0, 6'h00, 0, 1);
        step("strm2",    0, 16'h0002, 0, 6'h00, 0, 1);
        step("strm_rst", 1, 16'h0003, 0, 6'h00, 0, 1);
        step("post_idle",0, 16'h0004, 0, 6'h00, 0, 0);
        step("post_vld", 0, 16'h0004, 0, 6'h00, 0, 1);

        // Parity corner values.
        step("par_1",    0, 16'h0001, 0, 6'h00, 0, 1);
        step("par_3c",   0, 16'h0003, 1, 6'h00, 0, 1);
        step("par_3f",   0, 16'hFFFF, 1, 6'h3F, 1, 1);

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 15) == 0), 16'($urandom), 1'($urandom),
                 6'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
